// File: rtl/cmos_pll_ctrl_pkg.sv
// Shared types and default timing constants for the camera PLL reset/lock sequencer.
package cmos_pll_ctrl_pkg;

  localparam int RETRY_W           = 4;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRY     = 7;
  localparam int DEF_PWDN_CYCLES   = 5000;
  localparam int DEF_RSTN_CYCLES   = 1000;
  localparam int DEF_CNT_W         = 20;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_PWR_SEQ   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // States in which the PLL is held in reset.
  function automatic logic holds_pll_reset(input state_t st);
    return (st == ST_PLL_RST) || (st == ST_FAIL);
  endfunction

endpackage

// File: rtl/cmos_sync2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into the clkin domain.
module cmos_sync2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/cmos_pll_rst_ctrl.sv
// Camera PLL reset/lock sequencer with lock debounce, timeout/retry and sensor pin release.
// Optional sensor power sequencing (pwdn -> rst_n -> run) is built when CMOS_PWR_SEQ_EN is defined.
module cmos_pll_rst_ctrl
  import cmos_pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
`ifdef CMOS_PWR_SEQ_EN
  parameter int PWDN_CYCLES   = DEF_PWDN_CYCLES,
  parameter int RSTN_CYCLES   = DEF_RSTN_CYCLES,
`endif
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               soft_restart,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               pll_ready,
  output logic               cmos_pwdn,
  output logic               cmos_rst_n,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
);

  logic lock_s;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               pll_reset_reg, pll_reset_next;
  logic               pll_ready_reg, pll_ready_next;
  logic               cmos_pwdn_reg, cmos_pwdn_next;
  logic               cmos_rst_n_reg, cmos_rst_n_next;
  logic               fail_reg, fail_next;
`ifdef CMOS_PWR_SEQ_EN
  // Second half of PWR_SEQ: sensor out of reset, waiting before RUN.
  logic               rstn_phase_reg, rstn_phase_next;
`endif

  cmos_sync2ff u_lock_sync (
    .clk  (clkin),
    .srst (reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_reg      <= ST_PLL_RST;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      pll_reset_reg  <= 1'b1;
      pll_ready_reg  <= 1'b0;
      cmos_pwdn_reg  <= 1'b1;
      cmos_rst_n_reg <= 1'b0;
      fail_reg       <= 1'b0;
`ifdef CMOS_PWR_SEQ_EN
      rstn_phase_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      pll_reset_reg  <= pll_reset_next;
      pll_ready_reg  <= pll_ready_next;
      cmos_pwdn_reg  <= cmos_pwdn_next;
      cmos_rst_n_reg <= cmos_rst_n_next;
      fail_reg       <= fail_next;
`ifdef CMOS_PWR_SEQ_EN
      rstn_phase_reg <= rstn_phase_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    retry_next = retry_reg;
`ifdef CMOS_PWR_SEQ_EN
    rstn_phase_next = rstn_phase_reg;
`endif

    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == CNT_W'(RST_CYCLES - 1))
          state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
          if (retry_reg == RETRY_W'(MAX_RETRY)) begin
            state_next = ST_FAIL;
          end else begin
            retry_next = retry_reg + 1'b1;
            state_next = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
        end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
`ifdef CMOS_PWR_SEQ_EN
          state_next = ST_PWR_SEQ;
`else
          state_next = ST_RUN;
`endif
        end
      end
`ifdef CMOS_PWR_SEQ_EN
      ST_PWR_SEQ: begin
        if (!lock_s) begin
          state_next = ST_PLL_RST;
          retry_next = '0;
        end else if (!rstn_phase_reg && cnt_reg == CNT_W'(PWDN_CYCLES - 1)) begin
          rstn_phase_next = 1'b1;
          cnt_next        = '0;
        end else if (rstn_phase_reg && cnt_reg == CNT_W'(RSTN_CYCLES - 1)) begin
          state_next = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        cnt_next = cnt_reg;
        if (!lock_s) begin
          state_next = ST_PLL_RST;
          retry_next = '0;
        end
      end
      ST_FAIL: begin
        cnt_next = cnt_reg;
      end
      default: begin
        state_next = ST_PLL_RST;
        retry_next = '0;
      end
    endcase

    if (soft_restart) begin
      state_next = ST_PLL_RST;
      retry_next = '0;
    end

    // soft_restart inside PLL_RST keeps the state but must still restart the count.
    if (state_next != state_reg || soft_restart)
      cnt_next = '0;

`ifdef CMOS_PWR_SEQ_EN
    if (state_next != ST_PWR_SEQ)
      rstn_phase_next = 1'b0;
`endif
  end

  // Outputs are a registered decode of the next state so they change with the transition edge.
  always_comb begin
    pll_reset_next = holds_pll_reset(state_next);
    fail_next      = (state_next == ST_FAIL);
    pll_ready_next = (state_next == ST_RUN);
`ifdef CMOS_PWR_SEQ_EN
    cmos_pwdn_next  = !((state_next == ST_PWR_SEQ) || (state_next == ST_RUN));
    cmos_rst_n_next = (state_next == ST_RUN) ||
                      ((state_next == ST_PWR_SEQ) && rstn_phase_next);
`else
    cmos_pwdn_next  = !pll_ready_next;
    cmos_rst_n_next = pll_ready_next;
`endif
  end

  assign pll_reset  = pll_reset_reg;
  assign pll_ready  = pll_ready_reg;
  assign cmos_pwdn  = cmos_pwdn_reg;
  assign cmos_rst_n = cmos_rst_n_reg;
  assign fail       = fail_reg;
  assign retry_cnt  = retry_reg;

endmodule

// File: tb/tb_cmos_pll_rst_ctrl.sv
// Directed bench for cmos_pll_rst_ctrl with shortened timing; covers both CMOS_PWR_SEQ_EN builds.
module tb_cmos_pll_rst_ctrl;

  logic       clkin = 1'b0;
  logic       reset;
  logic       soft_restart;
  logic       pll_lock;
  logic       pll_reset;
  logic       pll_ready;
  logic       cmos_pwdn;
  logic       cmos_rst_n;
  logic       fail;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  // {pll_reset, pll_ready, cmos_pwdn, cmos_rst_n, fail, retry_cnt}
  localparam logic [8:0] RESET_OUTS = 9'b1_0_1_0_0_0000;
`ifdef CMOS_PWR_SEQ_EN
  localparam int SEQ_EXTRA = 11;
`else
  localparam int SEQ_EXTRA = 0;
`endif

  always #10 clkin = ~clkin;

  cmos_pll_rst_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
`ifdef CMOS_PWR_SEQ_EN
    .PWDN_CYCLES   (5),
    .RSTN_CYCLES   (6),
`endif
    .CNT_W         (20)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .soft_restart (soft_restart),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .pll_ready    (pll_ready),
    .cmos_pwdn    (cmos_pwdn),
    .cmos_rst_n   (cmos_rst_n),
    .fail         (fail),
    .retry_cnt    (retry_cnt)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      @(negedge clkin);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] outs();
    return {pll_reset, pll_ready, cmos_pwdn, cmos_rst_n, fail, retry_cnt};
  endfunction

  task automatic do_reset(input logic lock_val);
    reset        = 1'b1;
    soft_restart = 1'b0;
    pll_lock     = lock_val;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (pll_ready !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, pll_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    do_reset(1'b0);
    chk("reset_outs", {23'd0, outs()}, {23'd0, RESET_OUTS});

    // 1: pll_reset pulse width, then lock 10 cycles after it falls
    tick(3);
    chk("t1_rst_hi", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("t1_rst_lo", {31'd0, pll_reset}, 32'd0);
    tick(10);
    pll_lock = 1'b1;
    tick(10 + SEQ_EXTRA);
    chk("t1_rdy_early", {31'd0, pll_ready}, 32'd0);
    tick(1);
    chk("t1_rdy", {31'd0, pll_ready}, 32'd1);
    chk("t1_pins", {30'd0, cmos_pwdn, cmos_rst_n}, 32'b01);

    // 4: lock loss in RUN, then relock
    pll_lock = 1'b0;
    tick(2);
    chk("t4_rdy_hold", {31'd0, pll_ready}, 32'd1);
    tick(1);
    chk("t4_drop", {28'd0, pll_ready, cmos_rst_n, pll_reset, cmos_pwdn}, 32'b0011);
    chk("t4_retry", {28'd0, retry_cnt}, 32'd0);
    pll_lock = 1'b1;
    wait_ready("t4_relock", 100);

    // 2: lock never arrives -> three timeouts then FAIL
    do_reset(1'b0);
    tick(36);
    chk("t2_retry1", {28'd0, retry_cnt}, 32'd1);
    chk("t2_nofail1", {31'd0, fail}, 32'd0);
    tick(36);
    chk("t2_retry2", {28'd0, retry_cnt}, 32'd2);
    tick(35);
    chk("t2_nofail2", {31'd0, fail}, 32'd0);
    tick(1);
    chk("t2_fail", {28'd0, fail, pll_reset, retry_cnt[1:0]}, 32'b1110);
    tick(50);
    chk("t2_fail_hold", {28'd0, fail, pll_reset, retry_cnt[1:0]}, 32'b1110);
    soft_restart = 1'b1;
    tick(1);
    soft_restart = 1'b0;
    chk("t2_soft", {23'd0, outs()}, {23'd0, RESET_OUTS});
    tick(3);
    chk("t2_soft_rst", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("t2_soft_rlse", {31'd0, pll_reset}, 32'd0);

    // 3: 3-cycle lock glitch during STABLE restarts the debounce
    do_reset(1'b1);
    tick(8);
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(2);
    chk("t3_no_rdy", {31'd0, pll_ready}, 32'd0);
    tick(8 + SEQ_EXTRA);
    chk("t3_rdy_early", {31'd0, pll_ready}, 32'd0);
    tick(1);
    chk("t3_rdy", {31'd0, pll_ready}, 32'd1);
    chk("t3_retry", {28'd0, retry_cnt}, 32'd0);

    // 5: release of sensor pins after a clean debounce
    do_reset(1'b1);
    tick(12);
    chk("t5_pre", {29'd0, pll_ready, cmos_pwdn, cmos_rst_n}, 32'b010);
    tick(1);
`ifdef CMOS_PWR_SEQ_EN
    chk("t5_pwdn_fall", {29'd0, pll_ready, cmos_pwdn, cmos_rst_n}, 32'b000);
    tick(4);
    chk("t5_rstn_early", {31'd0, cmos_rst_n}, 32'd0);
    tick(1);
    chk("t5_rstn_rise", {30'd0, pll_ready, cmos_rst_n}, 32'b01);
    tick(5);
    chk("t5_rdy_early", {31'd0, pll_ready}, 32'd0);
    tick(1);
    chk("t5_rdy", {29'd0, pll_ready, cmos_pwdn, cmos_rst_n}, 32'b101);
`else
    chk("t5_release", {29'd0, pll_ready, cmos_pwdn, cmos_rst_n}, 32'b101);
`endif

    // 6: soft_restart coincident with lock_s rise, then reset mid-STABLE
    do_reset(1'b0);
    tick(5);
    pll_lock = 1'b1;
    tick(2);
    soft_restart = 1'b1;
    tick(1);
    soft_restart = 1'b0;
    chk("t6_soft", {23'd0, outs()}, {23'd0, RESET_OUTS});
    tick(3);
    chk("t6_rst_hi", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("t6_rst_lo", {31'd0, pll_reset}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("t6_reset", {23'd0, outs()}, {23'd0, RESET_OUTS});
    reset = 1'b0;
    tick(3);
    chk("t6_rst_hi2", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("t6_rst_lo2", {31'd0, pll_reset}, 32'd0);

    // soft_restart in the middle of PLL_RST restarts the reset pulse
    do_reset(1'b0);
    tick(2);
    soft_restart = 1'b1;
    tick(1);
    soft_restart = 1'b0;
    tick(3);
    chk("t7_rst_hi", {31'd0, pll_reset}, 32'd1);
    tick(1);
    chk("t7_rst_lo", {31'd0, pll_reset}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
